// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: float32 layout, exponent bias and the
// stage payloads of the int-to-float pipeline.
package fpu_pkg;

  localparam int unsigned FLOAT_BIAS    = 127;
  // Exponent of a value whose leading one sits in bit 31 of the magnitude.
  localparam int unsigned ITOF_EXP_BASE = FLOAT_BIAS + 31;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32_t;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [31:0] mag;
  } itof_s1_t;

  // The hidden bit (bit 31 of the normalized magnitude) is implied, so only
  // bits 30:0 travel to the rounding stage.
  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [7:0]  exp;
    logic [30:0] norm;
  } itof_s2_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter. The count is 0..31 and is
// meaningless when zero_o is set.
module lzc32 (
  input  logic [31:0] data_i,
  output logic [4:0]  cnt_o,
  output logic        zero_o
);

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) cnt_o = 5'(31 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 to IEEE-754 single converter, round-to-nearest-even,
// valid/ready on both sides. ITOF_INEXACT_EN adds the out_inexact port.
module itof_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef ITOF_INEXACT_EN
  output logic        out_inexact,
`endif
  output logic [31:0] out_data
);

  logic     s1_v_q, s2_v_q, out_valid_q;
  itof_s1_t s1_q, s1_d;
  itof_s2_t s2_q, s2_d;
  float32_t out_data_q, res_d;
  logic     inexact_d;
`ifdef ITOF_INEXACT_EN
  logic     inexact_q;
`endif

  logic s1_rdy, s2_rdy, s3_rdy;
  logic [4:0] lzc_cnt;
  logic       lzc_zero;

  // Each stage may load when it is empty or its content moves on this cycle.
  assign s3_rdy   = ~out_valid_q | out_ready;
  assign s2_rdy   = ~s2_v_q | s3_rdy;
  assign s1_rdy   = ~s1_v_q | s2_rdy;
  assign in_ready = s1_rdy;

  // S1: sign/magnitude split; -0x80000000 wraps to 0x80000000 = 2^31 unsigned.
  always_comb begin
    s1_d.sign = in_data[31];
    s1_d.mag  = in_data[31] ? 32'(-in_data) : in_data;
    s1_d.zero = (in_data == 32'd0);
  end

  lzc32 u_lzc (
    .data_i (s1_q.mag),
    .cnt_o  (lzc_cnt),
    .zero_o (lzc_zero)
  );

  // S2: normalize so the leading one lands in bit 31.
  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero | lzc_zero;
    s2_d.exp  = 8'(ITOF_EXP_BASE) - {3'b000, lzc_cnt};
    s2_d.norm = 31'(s1_q.mag << lzc_cnt);
  end

  // S3: round to nearest even; a mantissa carry bumps the exponent and
  // leaves the fraction at zero.
  logic [22:0] frac_raw, frac_rnd;
  logic        guard, sticky, rnd_up, carry;
  logic [7:0]  exp_rnd;

  always_comb begin
    frac_raw            = s2_q.norm[30:8];
    guard               = s2_q.norm[7];
    sticky              = |s2_q.norm[6:0];
    rnd_up              = guard & (sticky | frac_raw[0]);
    {carry, frac_rnd}   = {1'b0, frac_raw} + {23'd0, rnd_up};
    exp_rnd             = s2_q.exp + {7'd0, carry};
    res_d               = '0;
    inexact_d           = 1'b0;
    if (!s2_q.zero) begin
      res_d.sign = s2_q.sign;
      res_d.exp  = exp_rnd;
      res_d.frac = frac_rnd;
      inexact_d  = guard | sticky;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_data_q  <= '0;
`ifdef ITOF_INEXACT_EN
      inexact_q   <= 1'b0;
`endif
    end else begin
      if (s1_rdy) begin
        s1_v_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_rdy) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_q <= s2_d;
      end
      if (s3_rdy) begin
        out_valid_q <= s2_v_q;
        if (s2_v_q) begin
          out_data_q <= res_d;
`ifdef ITOF_INEXACT_EN
          inexact_q  <= inexact_d;
`endif
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef ITOF_INEXACT_EN
  assign out_inexact = inexact_q;
`else
  logic unused_inexact;
  assign unused_inexact = inexact_d;
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed values, backpressure, random
// bubbles against an arithmetic reference model, and reset mid-stream.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
`ifdef ITOF_INEXACT_EN
  logic        out_inexact;
`endif

  itof_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ITOF_INEXACT_EN
    .out_inexact (out_inexact),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic        s_in_ready, s_out_valid, s_out_inx;
  logic [31:0] s_out_data;

  // Reference: find the top set bit, keep 24 significant bits, round the
  // discarded remainder to nearest even. Returns {inexact, float bits}.
  function automatic logic [32:0] ref_itof(input logic [31:0] x);
    longint v, m, mant, rem, half;
    int e, sh;
    logic s;
    logic [7:0] ef;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 33'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    rem = 0;
    if (e <= 23) begin
      mant = m << (23 - e);
    end else begin
      sh   = e - 23;
      mant = m >> sh;
      rem  = m - (mant << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
      if (mant == (longint'(1) << 24)) begin
        mant = mant >> 1;
        e++;
      end
    end
    ef = 8'(e + 127);
    return {(rem != 0), s, ef, 23'(mant)};
  endfunction

  function automatic logic dut_inx();
`ifdef ITOF_INEXACT_EN
    return out_inexact;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: sample at the falling edge, log transfers, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_out_inx   = dut_inx();
    if (in_valid && in_ready) exp_q.push_back(ref_itof(in_data));
    if (out_valid && out_ready) got_q.push_back({s_out_inx, out_data});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
`ifdef ITOF_INEXACT_EN
    tests_run++;
    if (out_inexact !== 1'b0) begin fails++; $display("FAIL reset_out_inexact got %b want 0", out_inexact); end
`endif
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [31:0] vin  [8] = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h80000000,
                              32'd16777217, 32'd16777219, 32'd16777216};
    logic [31:0] vout [8] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h4F000000,
                              32'hCF000000, 32'h4B800000, 32'h4B800002, 32'h4B800000};
    logic        vinx [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_data   = vin[i];
      out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_accept[%0d] in_ready %b want 1", i, in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (lat < 10) begin
        @(negedge clk);
        if (out_valid === 1'b1) break;
        lat++;
      end
      tests_run++;
      if (lat != 3) begin fails++; $display("FAIL basic_latency[%0d] got %0d want 3", i, lat); end
      tests_run++;
      if (out_data !== vout[i]) begin fails++; $display("FAIL basic_data[%0d] in %h got %h want %h", i, vin[i], out_data, vout[i]); end
`ifdef ITOF_INEXACT_EN
      tests_run++;
      if (out_inexact !== vinx[i]) begin fails++; $display("FAIL basic_inexact[%0d] got %b want %b", i, out_inexact, vinx[i]); end
`else
      if (vinx[i] === 1'bx) $display("note: undefined inexact table entry %0d", i);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare_queues(input string name, input int want_n);
    tests_run++;
    if (got_q.size() != want_n || exp_q.size() != want_n) begin
      fails++;
      $display("FAIL %s_count got %0d results / %0d accepted want %0d", name, got_q.size(), exp_q.size(), want_n);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i][31:0] !== exp_q[i][31:0]) begin
        fails++;
        $display("FAIL %s_data[%0d] got %h want %h", name, i, got_q[i][31:0], exp_q[i][31:0]);
      end
`ifdef ITOF_INEXACT_EN
      tests_run++;
      if (got_q[i][32] !== exp_q[i][32]) begin
        fails++;
        $display("FAIL %s_inexact[%0d] got %b want %b", name, i, got_q[i][32], exp_q[i][32]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int sent, first_out;
    logic prev_stall;
    logic [31:0] prev_data;
    exp_q.delete();
    got_q.delete();
    sent = 0;
    first_out = -1;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 60 && got_q.size() < 10; c++) begin
      in_valid  = (sent < 10);
      in_data   = $urandom;
      out_ready = !(c >= 4 && c <= 8);
      cycle();
      if (in_valid && s_in_ready) sent++;
      if (s_out_valid && first_out < 0) first_out = c;
      if (c <= 3) begin
        tests_run++;
        if (s_in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_fill c=%0d got %b want 1", c, s_in_ready); end
      end else if (c <= 8) begin
        tests_run++;
        if (s_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full c=%0d got %b want 0", c, s_in_ready); end
      end
      if (prev_stall) begin
        tests_run++;
        if (s_out_valid !== 1'b1 || s_out_data !== prev_data) begin
          fails++;
          $display("FAIL bp_stall_hold c=%0d got v=%b %h want v=1 %h", c, s_out_valid, s_out_data, prev_data);
        end
      end
      prev_stall = s_out_valid && !out_ready;
      prev_data  = s_out_data;
    end
    in_valid = 1'b0;
    tests_run++;
    if (first_out != 3) begin fails++; $display("FAIL bp_first_latency got %0d want 3", first_out); end
    compare_queues("bp", 10);
  endtask

  task automatic test_bubbles();
    logic prev_stall;
    logic [31:0] prev_data;
    int n;
    exp_q.delete();
    got_q.delete();
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 1000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      case ($urandom_range(0, 4))
        0:       in_data = $urandom;
        1:       in_data = 32'($urandom_range(0, 2000)) - 32'd1000;
        2:       in_data = 32'd16777216 + 32'($urandom_range(0, 7));
        3:       in_data = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
        default: in_data = $urandom >> $urandom_range(0, 31);
      endcase
      cycle();
      if (prev_stall) begin
        tests_run++;
        if (s_out_valid !== 1'b1 || s_out_data !== prev_data) begin
          fails++;
          $display("FAIL bub_stall_hold c=%0d got v=%b %h want v=1 %h", c, s_out_valid, s_out_data, prev_data);
        end
      end
      prev_stall = s_out_valid && !out_ready;
      prev_data  = s_out_data;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got_q.size() < exp_q.size(); c++) cycle();
    n = exp_q.size();
    compare_queues("bub", n);
  endtask

  task automatic test_reset_midstream();
    int lat;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd100 + 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_preload_valid got %b want 1", out_valid); end
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_flush_valid got %b want 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_flush_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_stale_pre c=%0d got %b want 0", c, out_valid); end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = 32'd5;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_accept got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      lat++;
    end
    tests_run++;
    if (lat != 3) begin fails++; $display("FAIL rst_latency got %0d want 3", lat); end
    tests_run++;
    if (out_data !== 32'h40A00000) begin fails++; $display("FAIL rst_data got %h want 40a00000", out_data); end
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_stale_post c=%0d got %b want 0", c, out_valid); end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
